// File: rtl/led_trail_pwm.sv
// LED afterglow stage: each LED the sweep has lit holds a brightness level
// that decays over time, rendered through a shared free-running PWM counter.
module led_trail_pwm #(
    parameter int          PWM_BITS  = 4,
    parameter logic [15:0] DECAY_DIV = 16'd1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [7:0] i_led,
    output logic [7:0] o_led,
    output logic       o_decay_tick
);

    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    localparam logic [15:0]         DIV_LAST = DECAY_DIV - 16'd1;

    logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
    logic [15:0]              div_cnt_q, div_cnt_d;
    logic [7:0][PWM_BITS-1:0] level_q, level_d;
    logic [7:0]               led_q, led_d;

    // Both counters free-run regardless of enable so PWM phase stays continuous.
    assign o_decay_tick = (div_cnt_q == DIV_LAST);
    assign pwm_cnt_d    = pwm_cnt_q + 1'b1;
    assign div_cnt_d    = o_decay_tick ? 16'd0 : div_cnt_q + 16'd1;

    always_comb begin
        level_d = level_q;
        led_d   = '0;
        for (int k = 0; k < 8; k++) begin
            if (!i_enable)
                level_d[k] = '0;
            else if (i_led[k])
                level_d[k] = LVL_MAX;
            else if (o_decay_tick && (level_q[k] != '0))
                level_d[k] = level_q[k] - 1'b1;
            led_d[k] = i_enable & (i_led[k] | (level_q[k] > pwm_cnt_q));
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pwm_cnt_q <= '0;
            div_cnt_q <= '0;
            level_q   <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            div_cnt_q <= div_cnt_d;
            level_q   <= level_d;
            led_q     <= led_d;
        end
    end

    assign o_led = led_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: four instances with different decay dividers share
// stimulus; a per-cycle model feeds a scoreboard queue of expected o_led values.
module tb_led_trail_pwm;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b0;
    logic [7:0]      led = 8'h00;
    logic [3:0][7:0] o_led_w;
    logic [3:0]      tick_w;

    int vec  = 0;
    int miss = 0;

    int m_pwm [4];
    int m_div [4];
    int m_lvl [4][8];
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    led_trail_pwm #(.PWM_BITS(4), .DECAY_DIV(16'd4)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_led(led),
        .o_led(o_led_w[0]), .o_decay_tick(tick_w[0]));
    led_trail_pwm #(.PWM_BITS(4), .DECAY_DIV(16'd64)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_led(led),
        .o_led(o_led_w[1]), .o_decay_tick(tick_w[1]));
    led_trail_pwm #(.PWM_BITS(4), .DECAY_DIV(16'd2)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_led(led),
        .o_led(o_led_w[2]), .o_decay_tick(tick_w[2]));
    led_trail_pwm #(.PWM_BITS(4), .DECAY_DIV(16'd1)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_enable(en), .i_led(led),
        .o_led(o_led_w[3]), .o_decay_tick(tick_w[3]));

    function automatic int div_of(input int n);
        case (n)
            0:       return 4;
            1:       return 64;
            2:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset;
        for (int n = 0; n < 4; n++) begin
            m_pwm[n] = 0;
            m_div[n] = 0;
            for (int k = 0; k < 8; k++) m_lvl[n][k] = 0;
        end
        sb_q.delete();
    endtask

    // One clock: at the falling edge check the previous edge's result, then
    // drive new inputs and push what the next rising edge must produce.
    task automatic cyc(input logic [7:0] led_v, input logic en_v);
        logic [31:0] exp_w;
        logic [7:0]  e;
        bit          tk;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            exp_w = sb_q.pop_front();
            for (int n = 0; n < 4; n++) begin
                vec++;
                if (o_led_w[n] !== exp_w[n*8 +: 8]) begin
                    miss++;
                    $display("FAIL sb_led inst%0d t=%0t: got %h want %h", n, $time, o_led_w[n], exp_w[n*8 +: 8]);
                end
            end
        end
        for (int n = 0; n < 4; n++) begin
            tk = (m_div[n] == div_of(n) - 1);
            vec++;
            if (tick_w[n] !== tk) begin
                miss++;
                $display("FAIL sb_tick inst%0d t=%0t: got %b want %b", n, $time, tick_w[n], tk);
            end
        end
        led = led_v;
        en  = en_v;
        exp_w = '0;
        for (int n = 0; n < 4; n++) begin
            tk = (m_div[n] == div_of(n) - 1);
            for (int k = 0; k < 8; k++) begin
                e[k] = en_v & (led_v[k] | (m_lvl[n][k] > m_pwm[n]));
                if (!en_v)                       m_lvl[n][k] = 0;
                else if (led_v[k])               m_lvl[n][k] = 15;
                else if (tk && m_lvl[n][k] > 0)  m_lvl[n][k] = m_lvl[n][k] - 1;
            end
            exp_w[n*8 +: 8] = e;
            m_pwm[n] = (m_pwm[n] + 1) % 16;
            m_div[n] = tk ? 0 : m_div[n] + 1;
        end
        sb_q.push_back(exp_w);
    endtask

    task automatic release_reset;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int n = 0; n < 4; n++) begin
            vec++;
            if (o_led_w[n] !== 8'h00) begin
                miss++;
                $display("FAIL %s_led inst%0d: got %h want 00", tag, n, o_led_w[n]);
            end
            vec++;
            if (tick_w[n] !== (n == 3)) begin
                miss++;
                $display("FAIL %s_tick inst%0d: got %b want %b", tag, n, tick_w[n], (n == 3));
            end
        end
    endtask

    task automatic test_reset;
        #1;
        check_reset_outputs("rst_init");
        model_reset();
        en = 1'b1;
        release_reset();
    endtask

    task automatic test_reset_mid;
        int bad;
        repeat (50) cyc(8'h10, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        vec++;
        if (dut0.level_q !== '0) begin
            miss++;
            $display("FAIL rst_mid_lvl: got %h want 0", dut0.level_q);
        end
        model_reset();
        led = 8'h00;
        repeat (2) @(posedge clk);
        release_reset();
        bad = 0;
        repeat (64) begin
            cyc(8'h00, 1'b1);
            if (o_led_w[0] !== 8'h00) bad++;
        end
        vec++;
        if (bad !== 0) begin
            miss++;
            $display("FAIL rst_quiet: %0d lit cycles, want 0", bad);
        end
    endtask

    task automatic test_single_fade;
        int ticks, zero_at, want;
        cyc(8'h01, 1'b1);
        cyc(8'h00, 1'b1);
        vec++;
        if (dut0.level_q[0] !== 4'd15) begin
            miss++;
            $display("FAIL fade_load: got %0d want 15", dut0.level_q[0]);
        end
        ticks   = tick_w[0] ? 1 : 0;
        zero_at = -1;
        repeat (80) begin
            cyc(8'h00, 1'b1);
            want = (ticks >= 15) ? 0 : 15 - ticks;
            vec++;
            if (dut0.level_q[0] !== 4'(want)) begin
                miss++;
                $display("FAIL fade_lvl after %0d ticks: got %0d want %0d", ticks, dut0.level_q[0], want);
            end
            if (dut0.level_q[0] == 4'd0 && zero_at < 0) zero_at = ticks;
            if (tick_w[0]) ticks++;
        end
        vec++;
        if (zero_at !== 15) begin
            miss++;
            $display("FAIL fade_zero_ticks: got %0d want 15", zero_at);
        end
    endtask

    task automatic test_duty;
        int applied, highs;
        bit reached;
        cyc(8'h04, 1'b1);
        applied = 0;
        reached = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc(8'h00, 1'b1);
            if (applied == 3) begin
                reached = 1'b1;
                break;
            end
            if (tick_w[1]) applied++;
        end
        vec++;
        if (!reached) begin
            miss++;
            $display("FAIL duty_wait: got %0d ticks want 3 within budget", applied);
        end
        highs = 0;
        repeat (16) begin
            cyc(8'h00, 1'b1);
            if (o_led_w[1][2]) highs++;
        end
        vec++;
        if (highs !== 12) begin
            miss++;
            $display("FAIL duty_count: got %0d high cycles want 12", highs);
        end
    endtask

    task automatic test_coincide;
        int applied;
        cyc(8'h10, 1'b1);
        applied = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(8'h00, 1'b1);
            if (tick_w[0]) applied++;
            if (applied == 6) break;
        end
        repeat (3) cyc(8'h00, 1'b1);
        cyc(8'h08, 1'b1);
        vec++;
        if (tick_w[0] !== 1'b1) begin
            miss++;
            $display("FAIL coin_tick: got %b want 1", tick_w[0]);
        end
        cyc(8'h00, 1'b1);
        vec++;
        if (dut0.level_q[3] !== 4'd15) begin
            miss++;
            $display("FAIL coin_load: got %0d want 15", dut0.level_q[3]);
        end
        vec++;
        if (dut0.level_q[4] !== 4'd8) begin
            miss++;
            $display("FAIL coin_decay: got %0d want 8", dut0.level_q[4]);
        end
    endtask

    task automatic test_enable;
        int bad;
        cyc(8'h00, 1'b0);
        cyc(8'h00, 1'b1);
        vec++;
        if (o_led_w !== '0) begin
            miss++;
            $display("FAIL en_blank: got %h want 0", o_led_w);
        end
        vec++;
        if (dut0.level_q !== '0) begin
            miss++;
            $display("FAIL en_lvl: got %h want 0", dut0.level_q);
        end
        bad = 0;
        repeat (20) begin
            cyc(8'h00, 1'b1);
            if (o_led_w[0] !== 8'h00) bad++;
        end
        vec++;
        if (bad !== 0) begin
            miss++;
            $display("FAIL en_stale: %0d lit cycles want 0", bad);
        end
    endtask

    task automatic test_multi_load;
        logic [7:0] mask;
        mask = 8'hA5;
        cyc(mask, 1'b1);
        cyc(8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) begin
                vec++;
                if (dut0.level_q[k] !== 4'd15) begin
                    miss++;
                    $display("FAIL multi_lvl bit%0d: got %0d want 15", k, dut0.level_q[k]);
                end
            end
        end
        repeat (70) cyc(8'h00, 1'b1);
    endtask

    task automatic test_sweep;
        logic [7:0] seq [14];
        logic [7:0] prev;
        seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
        prev = 8'h00;
        for (int i = 0; i < 14; i++) begin
            cyc(seq[i], 1'b1);
            vec++;
            if ((o_led_w[2] & prev) !== prev) begin
                miss++;
                $display("FAIL sweep_lit step%0d: got %h want bits %h set", i, o_led_w[2], prev);
            end
            prev = seq[i];
        end
        repeat (40) cyc(8'h00, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_single_fade();
        test_duty();
        test_coincide();
        test_enable();
        test_multi_load();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
